// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with registered status flags, sticky error
// flags and a choice of registered-read or first-word-fall-through output.
module param_fifo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 1,
    parameter bit          FWFT      = 1'b0
) (
    input  logic                       param_fifo_clk_i,
    input  logic                       param_fifo_rst_i,
    input  logic                       param_fifo_writeflag_i,
    input  logic [DATA_W-1:0]          param_fifo_writedata_i,
    input  logic                       param_fifo_readflag_i,
    input  logic                       param_fifo_errclr_i,
    output logic [DATA_W-1:0]          param_fifo_readdata_o,
    output logic                       param_fifo_readvalid_o,
    output logic                       param_fifo_emptyflag_o,
    output logic                       param_fifo_fullflag_o,
    output logic                       param_fifo_afullflag_o,
    output logic                       param_fifo_aemptyflag_o,
    output logic [$clog2(DEPTH):0]     param_fifo_count_o,
    output logic                       param_fifo_overflow_o,
    output logic                       param_fifo_underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] L_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] L_AFULL  = CW'(AFULL_TH);
    localparam logic [CW-1:0] L_AEMPTY = CW'(AEMPTY_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_aempty;
    logic              r_ovf;
    logic              r_unf;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [CW-1:0]     w_count_d;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    always_comb begin
        w_rd_acc  = param_fifo_readflag_i && (r_count != '0);
        w_wr_acc  = param_fifo_writeflag_i && (!r_full || w_rd_acc);
        w_count_d = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    end

    always_ff @(posedge param_fifo_clk_i) begin
        if (param_fifo_rst_i && w_wr_acc) begin
            r_mem[r_wptr] <= param_fifo_writedata_i;
        end
    end

    always_ff @(posedge param_fifo_clk_i) begin
        if (!param_fifo_rst_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
            if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
            r_count  <= w_count_d;
            r_empty  <= (w_count_d == '0);
            r_full   <= (w_count_d == L_DEPTH);
            r_afull  <= (w_count_d >= L_AFULL);
            r_aempty <= (w_count_d <= L_AEMPTY);
            // A new error in the clear cycle wins over the clear.
            r_ovf    <= (r_ovf && !param_fifo_errclr_i)
                        || (param_fifo_writeflag_i && !w_wr_acc);
            r_unf    <= (r_unf && !param_fifo_errclr_i)
                        || (param_fifo_readflag_i && !w_rd_acc);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Masked while empty so stale storage never leaks out after reset.
            assign param_fifo_readdata_o  = r_empty ? '0 : r_mem[r_rptr];
            assign param_fifo_readvalid_o = !r_empty;
        end else begin : g_regread
            logic [DATA_W-1:0] r_rdata;
            logic              r_rvalid;

            always_ff @(posedge param_fifo_clk_i) begin
                if (!param_fifo_rst_i) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) r_rdata <= r_mem[r_rptr];
                end
            end

            assign param_fifo_readdata_o  = r_rdata;
            assign param_fifo_readvalid_o = r_rvalid;
        end
    endgenerate

    assign param_fifo_emptyflag_o  = r_empty;
    assign param_fifo_fullflag_o   = r_full;
    assign param_fifo_afullflag_o  = r_afull;
    assign param_fifo_aemptyflag_o = r_aempty;
    assign param_fifo_count_o      = r_count;
    assign param_fifo_overflow_o   = r_ovf;
    assign param_fifo_underflow_o  = r_unf;

endmodule

// File: tb/tb_param_fifo.sv
// Directed and randomized bench for param_fifo: a registered-read and a
// FWFT instance share stimulus and are checked against a queue model.
module tb_param_fifo;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AFT    = 6;
    localparam int unsigned AET    = 1;

    logic              clk;
    logic              rst;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              rdf;
    logic              clr;

    logic [DATA_W-1:0] rdata0, rdata1;
    logic              rvalid0, rvalid1;
    logic              empty0, empty1, full0, full1;
    logic              afull0, afull1, aempty0, aempty1;
    logic [3:0]        count0, count1;
    logic              ovf0, ovf1, unf0, unf1;

    param_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(1'b0)
    ) u_dut_reg (
        .param_fifo_clk_i       (clk),
        .param_fifo_rst_i       (rst),
        .param_fifo_writeflag_i (wr),
        .param_fifo_writedata_i (wdata),
        .param_fifo_readflag_i  (rdf),
        .param_fifo_errclr_i    (clr),
        .param_fifo_readdata_o  (rdata0),
        .param_fifo_readvalid_o (rvalid0),
        .param_fifo_emptyflag_o (empty0),
        .param_fifo_fullflag_o  (full0),
        .param_fifo_afullflag_o (afull0),
        .param_fifo_aemptyflag_o(aempty0),
        .param_fifo_count_o     (count0),
        .param_fifo_overflow_o  (ovf0),
        .param_fifo_underflow_o (unf0)
    );

    param_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(1'b1)
    ) u_dut_fwft (
        .param_fifo_clk_i       (clk),
        .param_fifo_rst_i       (rst),
        .param_fifo_writeflag_i (wr),
        .param_fifo_writedata_i (wdata),
        .param_fifo_readflag_i  (rdf),
        .param_fifo_errclr_i    (clr),
        .param_fifo_readdata_o  (rdata1),
        .param_fifo_readvalid_o (rvalid1),
        .param_fifo_emptyflag_o (empty1),
        .param_fifo_fullflag_o  (full1),
        .param_fifo_afullflag_o (afull1),
        .param_fifo_aemptyflag_o(aempty1),
        .param_fifo_count_o     (count1),
        .param_fifo_overflow_o  (ovf1),
        .param_fifo_underflow_o (unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue contents plus the externally visible state.
    logic [DATA_W-1:0] q[$];
    bit                m_ovf = 1'b0;
    bit                m_unf = 1'b0;
    bit                m_rv0 = 1'b0;
    logic [DATA_W-1:0] m_rd0 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit w, input logic [DATA_W-1:0] d,
                         input bit rd, input bit c);
        bit rd_ok;
        bit wr_ok;
        if (!r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rv0 = 1'b0;
            m_rd0 = '0;
        end else begin
            rd_ok = rd && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            m_ovf = (m_ovf && !c) || (w && !wr_ok);
            m_unf = (m_unf && !c) || (rd && !rd_ok);
            m_rv0 = rd_ok;
            if (rd_ok) m_rd0 = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        logic [DATA_W-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        chk("count",      32'(count0),  32'(n));
        chk("count_fwft", 32'(count1),  32'(n));
        chk("empty",      32'(empty0),  32'(n == 0));
        chk("full",       32'(full0),   32'(n == DEPTH));
        chk("afull",      32'(afull0),  32'(n >= AFT));
        chk("aempty",     32'(aempty0), 32'(n <= AET));
        chk("overflow",   32'(ovf0),    32'(m_ovf));
        chk("underflow",  32'(unf0),    32'(m_unf));
        chk("rvalid_reg", 32'(rvalid0), 32'(m_rv0));
        chk("rdata_reg",  rdata0,       m_rd0);
        chk("rvalid_fwft", 32'(rvalid1), 32'(n != 0));
        chk("rdata_fwft", rdata1,       head);
    endtask

    task automatic step(input bit r, input bit w, input logic [DATA_W-1:0] d,
                        input bit rd, input bit c);
        rst   = r;
        wr    = w;
        wdata = d;
        rdf   = rd;
        clr   = c;
        @(posedge clk);
        model(r, w, d, rd, c);
        #1;
        check_all();
    endtask

    logic [DATA_W-1:0] exp34 [5];

    initial begin
        rst = 1'b0; wr = 1'b0; wdata = '0; rdf = 1'b0; clr = 1'b0;
        exp34 = '{32'hAD00, 32'd1, 32'd2, 32'd3, 32'd5};

        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h1234, 1, 0);

        // Basic write then read order, ending in an underflow
        for (int i = 0; i < 5; i++) step(1, 1, exp34[i], 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 0);
            chk("seq_rdata", rdata0, exp34[i]);
            chk("seq_rvalid", 32'(rvalid0), 32'd1);
        end
        step(1, 0, 0, 1, 0);
        chk("seq_empty", 32'(empty0), 32'd1);
        chk("seq_underflow", 32'(unf0), 32'd1);
        chk("seq_hold", rdata0, 32'd5);
        step(1, 0, 0, 0, 1);
        chk("errclr", 32'(unf0), 32'd0);

        // Overflow on the ninth write, with afull/aempty tracked
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 32'(i), 0, 0);
            if (i < 8) begin
                chk("fill_afull", 32'(afull0), 32'(i + 1 >= AFT));
                chk("fill_aempty", 32'(aempty0), 32'(i + 1 <= AET));
            end
        end
        chk("ovf_count", 32'(count0), 32'd8);
        chk("ovf_full", 32'(full0), 32'd1);
        chk("ovf_flag", 32'(ovf0), 32'd1);
        // Clear and new error in the same cycle: flag stays set
        step(1, 1, 32'hBAD, 0, 1);
        chk("clr_vs_err", 32'(ovf0), 32'd1);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1, 0);
            chk("drain_rdata", rdata0, 32'(i));
            chk("drain_afull", 32'(afull0), 32'(7 - i >= AFT));
            chk("drain_aempty", 32'(aempty0), 32'(7 - i <= AET));
        end

        // Read and write together while full
        for (int i = 0; i < 8; i++) step(1, 1, 32'(i), 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h10 + 32'(i), 1, 0);
            chk("rw_full_count", 32'(count0), 32'd8);
            chk("rw_full_rdata", rdata0, 32'(i));
        end
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0);
        chk("rw_tail", rdata0, 32'h13);

        // Write into empty with a read: read rejected, write kept
        step(1, 1, 32'hC0DE, 1, 0);
        chk("wr_on_empty_count", 32'(count0), 32'd1);
        chk("wr_on_empty_unf", 32'(unf0), 32'd1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);

        // FWFT: word visible one cycle after write, no read issued
        step(1, 1, 32'h55, 0, 0);
        chk("fwft_valid", 32'(rvalid1), 32'd1);
        chk("fwft_data", rdata1, 32'h55);
        step(1, 0, 0, 1, 0);

        // Reset mid-operation discards contents and ignores requests
        for (int i = 0; i < 5; i++) step(1, 1, 32'hA0 + 32'(i), 0, 0);
        step(0, 1, 32'hEE, 1, 0);
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_rvalid", 32'(rvalid0), 32'd0);
        step(1, 1, 32'h77, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("post_rst_rdata", rdata0, 32'h77);

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 800; i++) begin
            int wp;
            int rp;
            wp = ((i / 100) % 2 == 1) ? 80 : 30;
            rp = 110 - wp;
            step(!($urandom_range(199) == 0),
                 ($urandom_range(99) < wp),
                 $urandom(),
                 ($urandom_range(99) < rp),
                 ($urandom_range(15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits, >= 1.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries; a power of two, >= 2.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2: almost-full threshold, 1..DEPTH-1.
REQ-004 SHALL have parameter AEMPTY_TH, default 1: almost-empty threshold, 1..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 selects registered-read mode, 1 selects first-word-fall-through mode.
REQ-006 SHALL have port param_fifo_clk_i  input  1: the single clock; all logic updates on its rising edge.
REQ-007 SHALL have port param_fifo_rst_i  input  1: the reset, which is synchronous and active-low.
REQ-008 SHALL have port param_fifo_writeflag_i  input  1: write request.
REQ-009 SHALL have port param_fifo_writedata_i  input  DATA_W: write data.
REQ-010 SHALL have port param_fifo_readflag_i  input  1: read request.
REQ-011 SHALL have port param_fifo_errclr_i  input  1: clears the sticky error flags.
REQ-012 SHALL have port param_fifo_readdata_o  output  DATA_W: read data.
REQ-013 SHALL have port param_fifo_readvalid_o  output  1: param_fifo_readdata_o holds a valid word.
REQ-014 SHALL have port param_fifo_emptyflag_o  output  1: count == 0.
REQ-015 SHALL have port param_fifo_fullflag_o  output  1: count == DEPTH.
REQ-016 SHALL have port param_fifo_afullflag_o  output  1: count >= AFULL_TH.
REQ-017 SHALL have port param_fifo_aemptyflag_o  output  1: count <= AEMPTY_TH.
REQ-018 SHALL have port param_fifo_count_o  output  clog2(DEPTH)+1: number of stored words.
REQ-019 SHALL have port param_fifo_overflow_o  output  1: sticky flag for a write that was dropped.
REQ-020 SHALL have port param_fifo_underflow_o  output  1: sticky flag for a read that was rejected.

Function
REQ-021 SHALL accept a write when writeflag=1 and (not full, or a read is accepted in the same cycle); the word is stored at the write pointer, which then increments modulo DEPTH.
REQ-022 SHALL accept a read when readflag=1 and count>0; the read pointer then increments modulo DEPTH.
REQ-023 SHALL apply a simultaneous accepted read and write in the same cycle with count unchanged, including when full.
REQ-024 SHALL NOT accept a read when empty, even if a write occurs in the same cycle; in that case the write is accepted and the underflow flag is set.
REQ-025 SHALL ignore a write when full and no read is accepted; storage and pointers are unchanged and the overflow flag is set on the next edge.
REQ-026 SHALL, with FWFT=0, present the popped word on readdata_o with readvalid_o=1 one cycle after the accepted read; otherwise readvalid_o=0 and readdata_o holds its last value.
REQ-027 SHALL, with FWFT=1, drive readdata_o with the head word and readvalid_o = !empty at all times; an accepted read exposes the next word on the following cycle.
REQ-028 SHALL, with FWFT=1, make the first word written into an empty FIFO visible one cycle after the write edge.
REQ-029 SHALL register count and all status flags, updating them on the same edge as the pointers.
REQ-030 SHALL keep overflow and underflow set until errclr=1 is sampled; if errclr and a new error occur in the same cycle, the flag stays set.
REQ-031 SHALL compute the pointers using clog2(DEPTH) bits with natural wrap-around, and count with one extra bit so that DEPTH is representable.

Reset
REQ-032 SHALL, when rst=0 at a rising edge, clear the pointers and count, set empty=1 and aempty=1, set full=0 and afull=0, set readvalid=0, clear both error flags, and set readdata_o to 0.
REQ-033 SHALL give reset priority over all requests, including mid-operation; reset discards stored contents, and requests in the reset cycle are ignored.

Verification
REQ-034 SHALL cover (DEPTH=8, FWFT=0): write 0xAD00, 1, 2, 3, 5, then hold read -> readdata 0xAD00, 1, 2, 3, 5, each one cycle after its read; then empty=1, underflow=1.
REQ-035 SHALL cover: 9 consecutive writes of 0..8 -> full=1 after the 8th, count=8, overflow=1, and reads return 0..7 only.
REQ-036 SHALL cover: fill to 8, then read+write together for 4 cycles with 0x10..0x13 -> count stays 8, and output order is 0..7 followed by 0x10..0x13.
REQ-037 SHALL cover: thresholds AFULL_TH=6 and AEMPTY_TH=1 -> afull rises at count=6 and aempty falls at count=2, tracked across fill and drain.
REQ-038 SHALL cover (FWFT=1): write 0x55 into an empty FIFO -> one cycle later readvalid=1 and readdata=0x55 with no read issued.
REQ-039 SHALL cover: rst=0 asserted with count=5 -> next cycle count=0, empty=1, readvalid=0, flags cleared; a subsequent write and read return the new data.
